// File: rtl/uart_pkg.sv
// UART shared types and defaults: receiver FSM states, default timing
// constants, and a divisor helper for the baud tick generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // 50 MHz / (19200 * 16), rounded
  localparam int TICK_DIV_DEF   = 163;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_tick_div(
    input int clk_hz,
    input int baud,
    input int os
  );
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: clock, reset in; tick out, high for one
// clock every DIV clocks. Shared by the UART receiver and transmitter.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = TICK_DIV_DEF
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: rx pin -> rx_data/rx_valid/rx_ready holding register, with
// busy, frame_err, overrun, parity_err pulses. UART_RX_PARITY_EN adds parity.
module uart_rx
  import uart_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = PARITY;
`else
  localparam rx_state_e AFTER_DATA = STOP;
`endif

  logic tick;

  uart_baud_tick #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  logic                 sync1_q, sync2_q, prev_q;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  logic fall, fire, good, room;

  assign fall = prev_q & ~sync2_q;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    // a drain with no load empties the register
    valid_d = valid_q & ~rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    fire    = 1'b0;
    good    = 1'b0;
    room    = ~valid_q | rx_ready;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // edge, not level: a held-low line never starts a frame
        if (fall) begin
          tcnt_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (tcnt_q == T_HALF) begin
            tcnt_d = '0;
            bcnt_d = '0;
            state_d = sync2_q ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == B_LAST) state_d = AFTER_DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            par_d   = sync2_q;
            state_d = STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            fire    = 1'b1;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fire) begin
      ferr_d = ~sync2_q;
      good   = sync2_q;
`ifdef UART_RX_PARITY_EN
      // even parity: data and parity bit XOR to zero
      perr_d = ^{shift_q, par_q};
      good   = sync2_q & ~perr_d;
`endif
      if (good) begin
        unique case (1'b1)
          room: begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
          !room: ovr_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at TICK_DIV=4, OVERSAMPLE=16 (64 clocks/bit).
// Define UART_RX_PARITY_EN for both DUT and bench to cover parity.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int ovr_cnt   = 0;
  int perr_cnt  = 0;
  int busy_cnt  = 0;
  logic [7:0] last_data = 8'h00;
  logic bad_par = 1'b0;

  always #10 clock = ~clock;

  uart_rx #(
    .TICK_DIV  (4),
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always @(negedge clock) begin
    if (rx_valid) begin
      valid_cnt = valid_cnt + 1;
      last_data = rx_data;
    end
    if (frame_err)  ferr_cnt = ferr_cnt + 1;
    if (overrun)    ovr_cnt  = ovr_cnt + 1;
    if (parity_err) perr_cnt = perr_cnt + 1;
    if (busy)       busy_cnt = busy_cnt + 1;
  end

  task automatic bit_out(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clock);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (PAR_EN) bit_out((^d) ^ bad_par);
    bit_out(stop);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", rx_valid);
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h want 00", rx_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if ({frame_err, overrun, parity_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_errs: got %b want 000",
               {frame_err, overrun, parity_err});
    end
    idle(20);
  endtask

  task automatic test_basic;
    int v0, f0, o0, b0;
    rx_ready = 1'b1;
    v0 = valid_cnt; f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_cnt;
    send_frame(8'h55, 1'b1);
    idle(BIT_CLKS);
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL basic_pulse: got %0d valid clocks want 1",
               valid_cnt - v0);
    end
    checks++;
    if (last_data !== 8'h55) begin
      errors++;
      $display("FAIL basic_data: got %h want 55", last_data);
    end
    checks++;
    if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin
      errors++;
      $display("FAIL basic_errs: got ferr %0d ovr %0d want 0 0",
               ferr_cnt - f0, ovr_cnt - o0);
    end
    checks++;
    if (busy_cnt - b0 < 600 || busy_cnt - b0 > 612) begin
      errors++;
      $display("FAIL basic_busy_len: got %0d want 600..612",
               busy_cnt - b0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_glitch;
    int v0, f0, o0, b0;
    v0 = valid_cnt; f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_cnt;
    rx = 1'b0;
    repeat (12) @(negedge clock);
    rx = 1'b1;
    repeat (28) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: got %b want 0 at 40 clocks", busy);
    end
    checks++;
    if (busy_cnt - b0 < 28 || busy_cnt - b0 > 33) begin
      errors++;
      $display("FAIL glitch_busy_len: got %0d want 28..33",
               busy_cnt - b0);
    end
    checks++;
    if (valid_cnt - v0 != 0) begin
      errors++;
      $display("FAIL glitch_valid: got %0d want 0", valid_cnt - v0);
    end
    checks++;
    if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin
      errors++;
      $display("FAIL glitch_errs: got ferr %0d ovr %0d want 0 0",
               ferr_cnt - f0, ovr_cnt - o0);
    end
    idle(BIT_CLKS);
  endtask

  task automatic test_frame_err;
    int v0, f0;
    rx_ready = 1'b1;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA3, 1'b0);
    idle(BIT_CLKS);
    checks++;
    if (ferr_cnt - f0 != 1) begin
      errors++;
      $display("FAIL ferr_pulse: got %0d want 1", ferr_cnt - f0);
    end
    checks++;
    if (valid_cnt - v0 != 0) begin
      errors++;
      $display("FAIL ferr_valid: got %0d want 0", valid_cnt - v0);
    end
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b1);
    idle(BIT_CLKS);
    checks++;
    if (valid_cnt - v0 != 1 || last_data !== 8'h3C) begin
      errors++;
      $display("FAIL ferr_next: got %0d x %h want 1 x 3c",
               valid_cnt - v0, last_data);
    end
    checks++;
    if (ferr_cnt - f0 != 0) begin
      errors++;
      $display("FAIL ferr_next_err: got %0d want 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_back_to_back;
    int o0, f0;
    rx_ready = 1'b0;
    o0 = ovr_cnt; f0 = ferr_cnt;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(BIT_CLKS);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h12) begin
      errors++;
      $display("FAIL b2b_hold: got %b/%h want 1/12", rx_valid, rx_data);
    end
    checks++;
    if (ovr_cnt - o0 != 1) begin
      errors++;
      $display("FAIL b2b_overrun: got %0d want 1", ovr_cnt - o0);
    end
    checks++;
    if (ferr_cnt - f0 != 0) begin
      errors++;
      $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt - f0);
    end
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got %b want 0", rx_valid);
    end
    idle(4);
  endtask

  task automatic test_reset_mid;
    int v0, f0, o0;
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    idle(32);
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(1'b0);
    rx = 1'b0;
    repeat (56) @(negedge clock);
    checks++;
    if (busy !== 1'b1 || rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
      errors++;
      $display("FAIL rmid_pre: got %b/%b/%h want 1/1/5a",
               busy, rx_valid, rx_data);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL rmid_clear: got %b/%b/%h want 0/0/00",
               busy, rx_valid, rx_data);
    end
    checks++;
    if ({frame_err, overrun, parity_err} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_errs: got %b want 000",
               {frame_err, overrun, parity_err});
    end
    rx_ready = 1'b1;
    repeat (7) @(negedge clock);
    idle(BIT_CLKS * 6);
    v0 = valid_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hC3, 1'b1);
    idle(BIT_CLKS);
    checks++;
    if (valid_cnt - v0 != 1 || last_data !== 8'hC3) begin
      errors++;
      $display("FAIL rmid_next: got %0d x %h want 1 x c3",
               valid_cnt - v0, last_data);
    end
    checks++;
    if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin
      errors++;
      $display("FAIL rmid_next_errs: got ferr %0d ovr %0d want 0 0",
               ferr_cnt - f0, ovr_cnt - o0);
    end
  endtask

  task automatic test_parity;
    int v0, p0, f0;
    rx_ready = 1'b1;
    v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    bad_par = 1'b1;
    send_frame(8'h07, 1'b1);
    bad_par = 1'b0;
    idle(BIT_CLKS);
    checks++;
    if (perr_cnt - p0 != 1) begin
      errors++;
      $display("FAIL par_bad_pulse: got %0d want 1", perr_cnt - p0);
    end
    checks++;
    if (valid_cnt - v0 != 0 || ferr_cnt - f0 != 0) begin
      errors++;
      $display("FAIL par_bad_side: got valid %0d ferr %0d want 0 0",
               valid_cnt - v0, ferr_cnt - f0);
    end
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1);
    idle(BIT_CLKS);
    checks++;
    if (valid_cnt - v0 != 1 || last_data !== 8'h07) begin
      errors++;
      $display("FAIL par_good: got %0d x %h want 1 x 07",
               valid_cnt - v0, last_data);
    end
    checks++;
    if (perr_cnt - p0 != 0) begin
      errors++;
      $display("FAIL par_good_err: got %0d want 0", perr_cnt - p0);
    end
  endtask

  initial begin
    rx       = 1'b1;
    rx_ready = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    if (PAR_EN) test_parity;
    checks++;
    if (perr_cnt != 0 && !PAR_EN) begin
      errors++;
      $display("FAIL parity_tied: got %0d pulses want 0", perr_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
